// File: rtl/branch_resolve_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_if
//   Groups the request, comparison-unit, response, redirect and flush signals
//   of the branch resolve unit.
//
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both 1. The requester must hold req_valid and every req_*
//   field stable until that edge. req_valid may rise at any time and does not
//   depend on req_ready. resp_valid and redirect_valid are single-cycle pulses
//   with no back-pressure. resp_* and redirect_pc are only meaningful while
//   their valid is high.
//
//   modport slave  : the branch resolve unit's view.
//   modport master : the environment's view (decode/issue, comparison unit,
//                    fetch).
// ----------------------------------------------------------------------------
interface branch_resolve_if #(
  parameter int OPD_LENGTH = 32
);
  // decode/issue -> unit
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_funct3;
  logic [OPD_LENGTH-1:0] req_rs1;
  logic [OPD_LENGTH-1:0] req_rs2;
  logic [OPD_LENGTH-1:0] req_pc;
  logic [OPD_LENGTH-1:0] req_imm;
  logic                  req_pred_taken;
  // unit <-> comparison unit
  logic [OPD_LENGTH-1:0] cmp_opd1;
  logic [OPD_LENGTH-1:0] cmp_opd2;
  logic [3:0]            cmp_op_select;
  logic [OPD_LENGTH-1:0] cmp_result;
  // unit -> issue / fetch
  logic                  resp_valid;
  logic                  resp_taken;
  logic                  resp_illegal;
  logic                  redirect_valid;
  logic [OPD_LENGTH-1:0] redirect_pc;
  logic                  flush;

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
           req_pred_taken, cmp_result,
    output req_ready, cmp_opd1, cmp_opd2, cmp_op_select,
           resp_valid, resp_taken, resp_illegal,
           redirect_valid, redirect_pc, flush
  );

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
           req_pred_taken, cmp_result,
    input  req_ready, cmp_opd1, cmp_opd2, cmp_op_select,
           resp_valid, resp_taken, resp_illegal,
           redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves RV32 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) using an
//   external combinational comparison unit. One branch is accepted per
//   handshake, its operands and compare select are driven to the comparison
//   unit, the result is sampled, and on a mispredict a PC redirect pulse is
//   issued followed by a FLUSH_CYCLES-long flush.
//
//   FSM: IDLE -> CMP -> RESOLVE -> (FLUSH | IDLE)
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   rst_n            synchronous active-low reset
//   bus              branch_resolve_if.slave (request, comparison unit,
//                    response, redirect, flush); OPD_LENGTH must match
//   mispredict_count saturating count of mispredicted branches
//   dbg_state        current FSM state (0 IDLE, 1 CMP, 2 RESOLVE, 3 FLUSH)
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int OPD_LENGTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_if.slave      bus,
  output logic [CNT_WIDTH-1:0] mispredict_count,
  output logic [1:0]           dbg_state
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMP     = 2'd1,
    S_RESOLVE = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t                state;
  logic [OPD_LENGTH-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic                  pred_q;
  logic [3:0]            op_sel_q;
  logic                  illegal_q;
  logic                  mispredict_q;
  logic [FC_W-1:0]       flush_cnt;

  logic [3:0]            op_sel_d;
  logic                  illegal_d;
  logic                  cmp_taken;
  logic                  cmp_mispredict;
  logic [OPD_LENGTH-1:0] target_taken;
  logic [OPD_LENGTH-1:0] target_fall;

  // Only bit 0 of the comparison result carries information.
  logic unused_cmp_bits;
  assign unused_cmp_bits = ^bus.cmp_result[OPD_LENGTH-1:1];

  // funct3 decode to the comparison unit's select encoding.
  always_comb begin
    op_sel_d  = 4'b0000;
    illegal_d = 1'b0;
    case (bus.req_funct3)
      3'b000:  op_sel_d = 4'b0000;  // EQ
      3'b001:  op_sel_d = 4'b0001;  // NE
      3'b100:  op_sel_d = 4'b0011;  // LT
      3'b101:  op_sel_d = 4'b0010;  // GE
      3'b110:  op_sel_d = 4'b0111;  // LTU
      3'b111:  op_sel_d = 4'b0110;  // GEU
      default: illegal_d = 1'b1;    // 010, 011
    endcase
  end

  // An illegal branch is never taken, so it can never mispredict.
  always_comb begin
    cmp_taken      = bus.cmp_result[0] & ~illegal_q;
    cmp_mispredict = (cmp_taken != pred_q) & ~illegal_q;
    target_taken   = pc_q + imm_q;               // wraps modulo 2^OPD_LENGTH
    target_fall    = pc_q + OPD_LENGTH'(4);
  end

  assign bus.cmp_opd1      = rs1_q;
  assign bus.cmp_opd2      = rs2_q;
  assign bus.cmp_op_select = op_sel_q;
  assign dbg_state         = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      rs1_q              <= '0;
      rs2_q              <= '0;
      pc_q               <= '0;
      imm_q              <= '0;
      pred_q             <= 1'b0;
      op_sel_q           <= 4'b0000;
      illegal_q          <= 1'b0;
      mispredict_q       <= 1'b0;
      flush_cnt          <= '0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_taken     <= 1'b0;
      bus.resp_illegal   <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.flush          <= 1'b0;
      mispredict_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            rs1_q         <= bus.req_rs1;
            rs2_q         <= bus.req_rs2;
            pc_q          <= bus.req_pc;
            imm_q         <= bus.req_imm;
            pred_q        <= bus.req_pred_taken;
            op_sel_q      <= op_sel_d;
            illegal_q     <= illegal_d;
            bus.req_ready <= 1'b0;
            state         <= S_CMP;
          end
        end

        // Response and redirect are registered here so they are stable
        // for the whole RESOLVE cycle.
        S_CMP: begin
          bus.resp_valid   <= 1'b1;
          bus.resp_taken   <= cmp_taken;
          bus.resp_illegal <= illegal_q;
          mispredict_q     <= cmp_mispredict;
          if (cmp_mispredict) begin
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= cmp_taken ? target_taken : target_fall;
          end
          state <= S_RESOLVE;
        end

        S_RESOLVE: begin
          bus.resp_valid     <= 1'b0;
          bus.redirect_valid <= 1'b0;
          if (mispredict_q) begin
            if (mispredict_count != {CNT_WIDTH{1'b1}})
              mispredict_count <= mispredict_count + 1'b1;
            bus.flush <= 1'b1;
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            state     <= S_FLUSH;
          end else begin
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end

        // flush_cnt counts remaining flush cycles after the current one.
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            bus.flush     <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
